// File: rtl/cassette_recorder_if.sv
// SDRAM write port of the cassette recorder.
// The recorder drives address, data and a held write request.
// The memory side answers with a one-cycle completion strobe.
interface cassette_recorder_if;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_data;
  logic        sdram_we;
  logic        sdram_ack;

  modport master (output sdram_addr, sdram_data, sdram_we, input sdram_ack);
  modport slave  (input sdram_addr, sdram_data, sdram_we, output sdram_ack);
endinterface

// File: rtl/cassette_recorder.sv
// Cassette recorder: demodulates the CPU's cassette-out FSK from the sound
// DAC, byte-aligns on 0x55 leader bytes and writes raw CAS bytes to SDRAM.
// A 1200 Hz cycle decodes as bit 0 and a 2400 Hz cycle as bit 1, LSB first.
// Optional macro CASREC_DEBUG_EN adds the 32-bit dbg status port.
//
// state  | meaning
// S_IDLE | motor off, decoder parked (a pending write still completes)
// S_HUNT | searching for a 0x55 leader byte, synced=0
// S_SYNC | byte aligned, every 8th bit emits a byte, synced=1
module cassette_recorder #(
  parameter logic [24:0] BASE_ADDR  = 25'h0,
  parameter int          MID        = 32,
  parameter int          HYST       = 4,
  parameter int          MIN_PERIOD = 200,
  parameter int          THRESH     = 560,
  parameter int          TIMEOUT    = 1500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Q,
  input  logic        motor,
  input  logic [5:0]  dac,
  input  logic        rewind,
  cassette_recorder_if.master bus,
  output logic [24:0] rec_len,
  output logic        synced,
  output logic        overflow
`ifdef CASREC_DEBUG_EN
  ,
  output logic [31:0] dbg
`endif
);

  localparam logic [6:0]  SIG_HI = 7'(MID + HYST);
  localparam logic [6:0]  SIG_LO = 7'(MID - HYST);
  localparam logic [11:0] P_MIN  = 12'(MIN_PERIOD);
  localparam logic [11:0] P_THR  = 12'(THRESH);
  localparam logic [11:0] P_TO   = 12'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_SYNC} state_t;

  state_t      state, state_nxt;
  logic        sig, sig_d, q_d;
  logic [11:0] period;
  logic [7:0]  shreg;
  logic [3:0]  bcnt, bcnt_nxt;
  logic        shift_en, emit;

  logic       q_tick, sig_rise, bit_valid, lost, dec_bit;
  logic [7:0] sh_next;

  assign q_tick    = Q & ~q_d;
  assign sig_rise  = sig & ~sig_d;
  assign lost      = (period > P_TO);
  assign bit_valid = sig_rise && (period >= P_MIN) && !lost;
  assign dec_bit   = (period < P_THR);
  assign sh_next   = {dec_bit, shreg[7:1]};
  assign synced    = (state == S_SYNC);

  // Zero-crossing comparator with hysteresis around the DAC midpoint
  always_ff @(posedge clk) begin
    if (reset)
      sig <= 1'b0;
    else if ({1'b0, dac} >= SIG_HI)
      sig <= 1'b1;
    else if ({1'b0, dac} < SIG_LO)
      sig <= 1'b0;
  end

  // Delayed copies for Q tick and comparator rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      q_d   <= 1'b0;
      sig_d <= 1'b0;
    end else begin
      q_d   <= Q;
      sig_d <= sig;
    end
  end

  // Cycle length in Q ticks; short glitch edges leave it running
  always_ff @(posedge clk) begin
    if (reset)
      period <= 12'd0;
    else if (sig_rise && (period >= P_MIN))
      period <= 12'd0;
    else if (q_tick && (period != 12'hFFF))
      period <= period + 12'd1;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next state, bit counting and byte emit decisions
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    shift_en  = 1'b0;
    emit      = 1'b0;
    if (!motor) begin
      state_nxt = S_IDLE;
      bcnt_nxt  = 4'd0;
    end else if (rewind) begin
      state_nxt = S_HUNT;
      bcnt_nxt  = 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_HUNT;
          bcnt_nxt  = 4'd0;
        end
        S_HUNT: begin
          bcnt_nxt = 4'd0;
          if (bit_valid) begin
            shift_en = 1'b1;
            if (sh_next == 8'h55) begin
              emit      = 1'b1;
              state_nxt = S_SYNC;
            end
          end
        end
        S_SYNC: begin
          if (lost) begin
            state_nxt = S_HUNT;
            bcnt_nxt  = 4'd0;
          end else if (bit_valid) begin
            shift_en = 1'b1;
            if (bcnt == 4'd7) begin
              emit     = 1'b1;
              bcnt_nxt = 4'd0;
            end else begin
              bcnt_nxt = bcnt + 4'd1;
            end
          end
        end
        default: begin
          state_nxt = S_IDLE;
          bcnt_nxt  = 4'd0;
        end
      endcase
    end
  end

  // Shift register and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= 8'h00;
      bcnt  <= 4'd0;
    end else begin
      bcnt <= bcnt_nxt;
      if (shift_en)
        shreg <= sh_next;
    end
  end

  // SDRAM write handshake; an ack retires before a same-cycle emit
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sdram_addr <= BASE_ADDR;
      bus.sdram_data <= 8'h00;
      bus.sdram_we   <= 1'b0;
      rec_len        <= 25'd0;
      overflow       <= 1'b0;
    end else if (rewind) begin
      bus.sdram_addr <= BASE_ADDR;
      bus.sdram_we   <= 1'b0;
      rec_len        <= 25'd0;
      overflow       <= 1'b0;
    end else begin
      if (bus.sdram_we && bus.sdram_ack) begin
        bus.sdram_we   <= 1'b0;
        bus.sdram_addr <= bus.sdram_addr + 25'd1;
        rec_len        <= rec_len + 25'd1;
      end
      if (emit) begin
        if (!bus.sdram_we || bus.sdram_ack) begin
          bus.sdram_data <= sh_next;
          bus.sdram_we   <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

`ifdef CASREC_DEBUG_EN
  logic [11:0] last_period;

  // Length of the most recently decoded cycle
  always_ff @(posedge clk) begin
    if (reset)
      last_period <= 12'd0;
    else if (bit_valid)
      last_period <= period;
  end

  assign dbg = {last_period, shreg, bcnt, state, sig, synced, overflow, motor, 2'b00};
`endif

endmodule

// File: tb/tb_cassette_recorder.sv
// Directed bench for cassette_recorder with timing parameters scaled down by
// ten (bit 1 = 37 ticks, bit 0 = 75 ticks) and one Q tick every two clocks.
module tb_cassette_recorder;
  localparam logic [24:0] BASE   = 25'h100;
  localparam int          T1     = 37;
  localparam int          T0     = 75;
  localparam logic [5:0]  DAC_HI = 6'd52;
  localparam logic [5:0]  DAC_LO = 6'd12;

  logic        clk, Q, reset, motor, rewind;
  logic [5:0]  dac;
  logic [24:0] rec_len;
  logic        synced, overflow;
`ifdef CASREC_DEBUG_EN
  logic [31:0] dbg;
`endif

  cassette_recorder_if bus ();

  cassette_recorder #(
    .BASE_ADDR(BASE), .MID(32), .HYST(4),
    .MIN_PERIOD(20), .THRESH(56), .TIMEOUT(150)
  ) dut (
    .clk(clk), .reset(reset), .Q(Q), .motor(motor), .dac(dac),
    .rewind(rewind), .bus(bus), .rec_len(rec_len), .synced(synced),
    .overflow(overflow)
`ifdef CASREC_DEBUG_EN
    , .dbg(dbg)
`endif
  );

  typedef struct {
    logic [7:0] din;
    int         glitch_bit;
    logic [7:0] exp_data;
  } vec_t;

  vec_t        vecs [6];
  int          n_chk, n_fail, ack_wait;
  bit          hold_ack;
  logic [24:0] log_addr [$];
  logic [7:0]  log_data [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Q toggles on clock falling edges: one rising edge every two clocks
  initial begin
    Q = 1'b0;
    forever #10 Q = ~Q;
  end

  // SDRAM model: acks three cycles after a request, logs accepted writes
  initial begin
    bus.sdram_ack = 1'b0;
    ack_wait = 0;
    forever begin
      @(negedge clk);
      if (bus.sdram_ack) begin
        bus.sdram_ack = 1'b0;
      end else if (bus.sdram_we && !hold_ack) begin
        if (ack_wait == 2) begin
          bus.sdram_ack = 1'b1;
          log_addr.push_back(bus.sdram_addr);
          log_data.push_back(bus.sdram_data);
          ack_wait = 0;
        end else begin
          ack_wait++;
        end
      end else begin
        ack_wait = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_wr(input string name, input int idx, input logic [24:0] ea, input logic [7:0] ed);
    if (idx < log_addr.size()) begin
      check({name, "_addr"}, 32'(log_addr[idx]), 32'(ea));
      check({name, "_data"}, 32'(log_data[idx]), 32'(ed));
    end else begin
      check({name, "_missing"}, 32'hFFFFFFFF, 32'(ea));
    end
  endtask

  task automatic tick_wait(input int n);
    repeat (2 * n) @(negedge clk);
  endtask

  task automatic fsk_cycle(input int len, input bit glitch);
    if (!glitch) begin
      dac = DAC_HI; tick_wait(len / 2);
      dac = DAC_LO; tick_wait(len - len / 2);
    end else begin
      dac = DAC_HI; tick_wait(10);
      dac = DAC_LO; tick_wait(2);
      dac = DAC_HI; tick_wait(5);
      dac = DAC_LO; tick_wait(len - 17);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int first, input int n, input int gbit);
    for (int i = first; i < first + n; i++)
      fsk_cycle(b[i] ? T1 : T0, i == gbit);
  endtask

  task automatic close_edge();
    dac = DAC_HI; tick_wait(10);
    dac = DAC_LO; tick_wait(5);
  endtask

  task automatic idle_gap(input int n);
    dac = DAC_LO;
    tick_wait(n);
  endtask

  initial begin
    vecs[0] = '{8'h3C, -1, 8'h3C};
    vecs[1] = '{8'hA5,  3, 8'hA5};
    vecs[2] = '{8'h00, -1, 8'h00};
    vecs[3] = '{8'hFF, -1, 8'hFF};
    vecs[4] = '{8'h01, -1, 8'h01};
    vecs[5] = '{8'h80, -1, 8'h80};
    n_chk = 0; n_fail = 0; hold_ack = 1'b0;
    reset = 1'b1; motor = 1'b0; rewind = 1'b0; dac = DAC_LO;

    repeat (3) @(negedge clk);
    check("rst_addr", 32'(bus.sdram_addr), 32'(BASE));
    check("rst_data", 32'(bus.sdram_data), 32'h0);
    check("rst_we", 32'(bus.sdram_we), 32'h0);
    check("rst_len", 32'(rec_len), 32'h0);
    check("rst_synced", 32'(synced), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    motor = 1'b1;

    // leader sync, then the table of data bytes (one with a glitch spike)
    idle_gap(200);
    send_bits(8'h55, 0, 8, -1);
    check("sync_before_8th", 32'(synced), 32'h0);
    send_bits(8'h55, 0, 1, -1);
    check("sync_after_8th", 32'(synced), 32'h1);
    send_bits(8'h55, 1, 7, -1);
    for (int k = 0; k < 14; k++) send_bits(8'h55, 0, 8, -1);
    for (int i = 0; i < 6; i++) send_bits(vecs[i].din, 0, 8, vecs[i].glitch_bit);
    close_edge();
    check("s1_synced", 32'(synced), 32'h1);
    check("s1_count", 32'(log_addr.size()), 32'd22);
    for (int i = 0; i < 16; i++) check_wr($sformatf("leader%0d", i), i, BASE + 25'(i), 8'h55);
    for (int i = 0; i < 6; i++) check_wr($sformatf("vec%0d", i), 16 + i, BASE + 25'(16 + i), vecs[i].exp_data);
    check("s1_len", 32'(rec_len), 32'd22);
    check("s1_ovf", 32'(overflow), 32'h0);

    // silence without edges drops sync
    idle_gap(200);
    check("idle_timeout", 32'(synced), 32'h0);

    // timeout after four data bits discards the partial byte
    send_bits(8'h55, 0, 8, -1);
    send_bits(8'h55, 0, 8, -1);
    send_bits(8'h00, 0, 4, -1);
    check("s2_synced", 32'(synced), 32'h1);
    idle_gap(200);
    check("to_synced", 32'(synced), 32'h0);
    check("to_count", 32'(log_addr.size()), 32'd24);
    check_wr("s2_l0", 22, BASE + 25'd22, 8'h55);
    check_wr("s2_l1", 23, BASE + 25'd23, 8'h55);
    check("to_len", 32'(rec_len), 32'd24);

    // backpressure: first byte held, second dropped, rewind clears
    send_bits(8'h55, 0, 8, -1);
    send_bits(8'h55, 0, 8, -1);
    send_bits(8'h3C, 0, 1, -1);
    hold_ack = 1'b1;
    send_bits(8'h3C, 1, 7, -1);
    send_bits(8'hC3, 0, 8, -1);
    close_edge();
    check("bp_count", 32'(log_addr.size()), 32'd26);
    check("bp_we", 32'(bus.sdram_we), 32'h1);
    check("bp_data", 32'(bus.sdram_data), 32'h3C);
    check("bp_addr", 32'(bus.sdram_addr), 32'(BASE + 25'd26));
    check("bp_ovf", 32'(overflow), 32'h1);
    check("bp_len", 32'(rec_len), 32'd26);
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    check("rw_we", 32'(bus.sdram_we), 32'h0);
    check("rw_addr", 32'(bus.sdram_addr), 32'(BASE));
    check("rw_len", 32'(rec_len), 32'h0);
    check("rw_ovf", 32'(overflow), 32'h0);
    check("rw_synced", 32'(synced), 32'h0);
    hold_ack = 1'b0;

    // motor drop mid-byte parks the decoder in IDLE
    idle_gap(200);
    send_bits(8'h55, 0, 8, -1);
    send_bits(8'h55, 0, 8, -1);
    send_bits(8'hFF, 0, 3, -1);
    check("s4_synced", 32'(synced), 32'h1);
    check("s4_count", 32'(log_addr.size()), 32'd28);
    check_wr("s4_l0", 26, BASE, 8'h55);
    check_wr("s4_l1", 27, BASE + 25'd1, 8'h55);
    motor = 1'b0;
    tick_wait(2);
    check("motor_off_synced", 32'(synced), 32'h0);
    send_bits(8'h55, 0, 8, -1);
    send_bits(8'h55, 0, 8, -1);
    close_edge();
    check("idle_no_sync", 32'(synced), 32'h0);
    check("idle_no_write", 32'(log_addr.size()), 32'd28);
    idle_gap(200);
    motor = 1'b1;
    tick_wait(2);
    check("motor_on_hunt", 32'(synced), 32'h0);
    send_bits(8'h55, 0, 8, -1);
    send_bits(8'h55, 0, 8, -1);
    close_edge();
    check("resync", 32'(synced), 32'h1);
    check("resync_count", 32'(log_addr.size()), 32'd30);
    check_wr("s4_l2", 28, BASE + 25'd2, 8'h55);
    check_wr("s4_l3", 29, BASE + 25'd3, 8'h55);
    check("s4_len", 32'(rec_len), 32'd4);

    // reset while a write is pending drops the request
    hold_ack = 1'b1;
    idle_gap(200);
    send_bits(8'h00, 0, 8, -1);
    send_bits(8'h55, 0, 8, -1);
    close_edge();
    check("rm_we_before", 32'(bus.sdram_we), 32'h1);
    check("rm_data_before", 32'(bus.sdram_data), 32'h55);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rm_we", 32'(bus.sdram_we), 32'h0);
    check("rm_addr", 32'(bus.sdram_addr), 32'(BASE));
    check("rm_len", 32'(rec_len), 32'h0);
    check("rm_synced", 32'(synced), 32'h0);
    hold_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cassette_recorder.md
Name: cassette_recorder

Overview:
- Record-direction counterpart of the cassette playback block.
- Demodulates the machine's cassette-out FSK from the 6-bit DAC: 1200 Hz cycle = bit 0, 2400 Hz cycle = bit 1, LSB first.
- Byte-aligns the bitstream on leader bytes (0x55) and writes raw CAS-format bytes into SDRAM.
- Sits beside the cassette player, muxed onto the SDRAM port whenever recording is active.

Parameters:
- BASE_ADDR, 25'h0, SDRAM byte address of the first recorded byte.
- MID, 32, DAC midpoint for the zero-crossing comparator.
- HYST, 4, comparator hysteresis in DAC LSBs.
- MIN_PERIOD, 200, shortest valid cycle in Q ticks; shorter cycles are glitches.
- THRESH, 560, cycles shorter than this decode as bit 1, others as bit 0 (nominal 373 / 745 ticks).
- TIMEOUT, 1500, cycle length in Q ticks beyond which sync is lost.

Ports:
- clk  input  1  system clock (57.272 MHz)
- reset  input  1  synchronous, active-high
- Q  input  1  CPU Q clock level; rising edge detected internally = one tick
- motor  input  1  cassette relay; recording enabled while high
- dac  input  6  CPU sound DAC value
- rewind  input  1  level; returns write pointer to BASE_ADDR
- sdram_addr  output  25  write address
- sdram_data  output  8  write data
- sdram_we  output  1  write request, held until acked
- sdram_ack  input  1  one-cycle write-complete strobe
- rec_len  output  25  bytes committed since last rewind/reset
- synced  output  1  byte alignment established
- overflow  output  1  sticky: a byte was dropped
- dbg  output  32  present only with CASREC_DEBUG_EN

Behaviour:
- Reset values:
  - sdram_addr = BASE_ADDR; sdram_data = 0; sdram_we = 0.
  - rec_len = 0; synced = 0; overflow = 0.
  - Internal state: FSM = IDLE, period counter = 0, shift register = 0, bit count = 0, comparator = 0.
- Comparator:
  - sig sets when dac >= MID+HYST and clears when dac < MID-HYST; otherwise holds.
  - Registered, so one cycle of latency.
- Period counter:
  - 12-bit; increments on each Q tick and saturates at 4095.
  - On a sig rising edge with period >= MIN_PERIOD: decode bit = (period < THRESH), then clear the counter.
  - If period < MIN_PERIOD: edge ignored, counter keeps running.
  - If period > TIMEOUT: no bit is decoded; FSM goes to HUNT; counter cleared.
  - A counter reaching TIMEOUT+1 without an edge also forces HUNT.
- Shift register:
  - Each decoded bit shifts right, new bit entering at bit 7.
- FSM:
  - IDLE: entered whenever motor=0, from any state. A pending write still completes.
  - IDLE -> HUNT when motor rises.
  - HUNT: synced=0. After each decoded bit, if shift register == 0x55, emit byte 0x55, clear bit count, go to SYNC.
  - SYNC: synced=1. Each 8th decoded bit emits the shift register as a byte and clears bit count.
  - SYNC -> HUNT on timeout; the partial byte is discarded.
- Emit:
  - If no write is pending: latch sdram_data, assert sdram_we next cycle.
  - If a write is pending: drop the byte and set overflow.
- Write handshake:
  - sdram_we holds with stable addr and data until sdram_ack.
  - On ack: sdram_we=0, sdram_addr+1, rec_len+1 (25-bit wrap).
  - An emit and an ack in the same cycle: ack retires first, the new byte is accepted.
- Rewind:
  - Same cycle effect: sdram_addr=BASE_ADDR, rec_len=0, overflow=0.
  - A pending write is aborted, sdram_we=0.
  - FSM to HUNT if motor=1.
- reset mid-write: sdram_we drops immediately; the byte is lost.

Optional Feature:
- Macro: CASREC_DEBUG_EN.
- When defined: dbg = {last valid period[11:0], shift register[7:0], bit count[3:0], FSM state[1:0], sig, synced, overflow, motor, 2'b0}. The last valid period is registered on each decode. This feeds the overlay debug lines.
- When undefined: the dbg port does not exist and none of its logic is built.

Test Plan:
- Leader sync: motor=1, DAC square 32±20, 16×0x55 at 2400/1200 Hz on the Q grid -> synced=1 after the first 8 bits; 16 writes of 0x55 at addrs 0..15; rec_len=16.
- Data byte: after leader, send 0x3C LSB-first -> one write at addr 16, data 0x3C.
- Glitch rejection: 50-tick spike mid-cycle, then byte 0xA5 -> 0xA5 decoded correctly, no extra byte.
- Timeout: 2000-tick silence after 4 data bits -> synced=0, partial byte discarded, no write.
- Backpressure: withhold sdram_ack across two byte emits -> first byte held, second dropped, overflow=1; a later rewind clears overflow, rec_len=0, addr=BASE_ADDR.
- Motor drop mid-byte: motor=0 after 3 bits -> FSM IDLE, no write; motor=1 -> HUNT, synced=0.
